id_ex_stage: RTL

//  ID/EX pipeline register for the 5-stage MIPS core. Captures the decoded control signals

---
 rtl/mips_pkg.sv | 30 +++
 rtl/load_use_detect.sv | 30 +++
 rtl/id_ex_stage.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, ALU op encodings and the control bundle
// produced by control_unit and carried down the pipe.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   // The nine control bits decoded in ID and consumed in EX/MEM/WB
   typedef struct packed {
      logic       mem_write;
      logic       reg_write;
      logic       reg_dest;
      logic       mem_to_reg;
      logic       alu_src;
      logic [1:0] alu_op;
      logic       branch;
      logic       mem_read;
   } ctrl_t;

   // A bubble carries no side effects
   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detection: a load in EX whose destination is read by the ID instruction
// must delay that instruction by one cycle. Purely combinational.
module load_use_detect #(
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                  ex_valid_i,
   input  logic                  ex_mem_read_i,
   input  logic [REG_ADDR_W-1:0] ex_rt_i,
   input  logic                  id_valid_i,
   input  logic                  id_alu_src_i,
   input  logic                  id_mem_write_i,
   input  logic                  id_branch_i,
   input  logic [REG_ADDR_W-1:0] id_rs_i,
   input  logic [REG_ADDR_W-1:0] id_rt_i,
   output logic                  load_use_o
);

   logic uses_rt;
   logic ex_is_load;

   // rt is only a source for R-type ALU ops, stores (data) and branches (compare)
   always_comb begin
      uses_rt    = !id_alu_src_i | id_mem_write_i | id_branch_i;
      // $0 is hard-wired, so a load targeting it can never feed a consumer
      ex_is_load = ex_valid_i & ex_mem_read_i & (ex_rt_i != '0);
      load_use_o = ex_is_load & id_valid_i &
                   ((ex_rt_i == id_rs_i) | (uses_rt & (ex_rt_i == id_rt_i)));
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation and bubble insertion on flush
// or stall. Optional statistics counters are built when ID_EX_STATS_EN is defined.
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic                  id_mem_write,
   input  logic                  id_reg_write,
   input  logic                  id_reg_dest,
   input  logic                  id_mem_to_reg,
   input  logic                  id_alu_src,
   input  logic [1:0]            id_alu_op,
   input  logic                  id_branch,
   input  logic                  id_mem_read,
   input  logic [DATA_W-1:0]     id_rs_data,
   input  logic [DATA_W-1:0]     id_rt_data,
   input  logic [DATA_W-1:0]     id_imm,
   input  logic [DATA_W-1:0]     id_pc_plus4,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic [5:0]            id_funct,
   input  logic                  flush,
   output logic                  stall_out,
   output logic                  ex_valid,
   output logic                  ex_mem_write,
   output logic                  ex_reg_write,
   output logic                  ex_reg_dest,
   output logic                  ex_mem_to_reg,
   output logic                  ex_alu_src,
   output logic [1:0]            ex_alu_op,
   output logic                  ex_branch,
   output logic                  ex_mem_read,
   output logic [DATA_W-1:0]     ex_rs_data,
   output logic [DATA_W-1:0]     ex_rt_data,
   output logic [DATA_W-1:0]     ex_imm,
   output logic [DATA_W-1:0]     ex_pc_plus4,
   output logic [REG_ADDR_W-1:0] ex_rs,
   output logic [REG_ADDR_W-1:0] ex_rt,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic [5:0]            ex_funct
`ifdef ID_EX_STATS_EN
   ,
   output logic [31:0]           stall_cnt,
   output logic [31:0]           flush_cnt
`endif
);

   logic                  valid_d, valid_q;
   ctrl_t                 ctrl_d, ctrl_q;
   logic [DATA_W-1:0]     rs_data_d, rs_data_q;
   logic [DATA_W-1:0]     rt_data_d, rt_data_q;
   logic [DATA_W-1:0]     imm_d, imm_q;
   logic [DATA_W-1:0]     pc_plus4_d, pc_plus4_q;
   logic [REG_ADDR_W-1:0] rs_d, rs_q;
   logic [REG_ADDR_W-1:0] rt_d, rt_q;
   logic [REG_ADDR_W-1:0] rd_d, rd_q;
   logic [5:0]            funct_d, funct_q;
   logic                  load_use;

   load_use_detect #(
      .REG_ADDR_W(REG_ADDR_W)
   ) u_load_use_detect (
      .ex_valid_i     (valid_q),
      .ex_mem_read_i  (ctrl_q.mem_read),
      .ex_rt_i        (rt_q),
      .id_valid_i     (id_valid),
      .id_alu_src_i   (id_alu_src),
      .id_mem_write_i (id_mem_write),
      .id_branch_i    (id_branch),
      .id_rs_i        (id_rs),
      .id_rt_i        (id_rt),
      .load_use_o     (load_use)
   );

   // A flush kills the ID instruction anyway, so there is nothing to stall for
   assign stall_out = load_use & !flush;

   // Next EX contents: capture ID, or load an all-zero bubble on flush/stall/invalid
   always_comb begin
      valid_d    = 1'b0;
      ctrl_d     = CTRL_NOP;
      rs_data_d  = '0;
      rt_data_d  = '0;
      imm_d      = '0;
      pc_plus4_d = '0;
      rs_d       = '0;
      rt_d       = '0;
      rd_d       = '0;
      funct_d    = '0;
      if (!flush && !load_use && id_valid) begin
         valid_d           = 1'b1;
         ctrl_d.mem_write  = id_mem_write;
         ctrl_d.reg_write  = id_reg_write;
         ctrl_d.reg_dest   = id_reg_dest;
         ctrl_d.mem_to_reg = id_mem_to_reg;
         ctrl_d.alu_src    = id_alu_src;
         ctrl_d.alu_op     = id_alu_op;
         ctrl_d.branch     = id_branch;
         ctrl_d.mem_read   = id_mem_read;
         rs_data_d         = id_rs_data;
         rt_data_d         = id_rt_data;
         imm_d             = id_imm;
         pc_plus4_d        = id_pc_plus4;
         rs_d              = id_rs;
         rt_d              = id_rt;
         rd_d              = id_rd;
         funct_d           = id_funct;
      end
   end

   // Pipeline register, updated every cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         ctrl_q     <= CTRL_NOP;
         rs_data_q  <= '0;
         rt_data_q  <= '0;
         imm_q      <= '0;
         pc_plus4_q <= '0;
         rs_q       <= '0;
         rt_q       <= '0;
         rd_q       <= '0;
         funct_q    <= '0;
      end else begin
         valid_q    <= valid_d;
         ctrl_q     <= ctrl_d;
         rs_data_q  <= rs_data_d;
         rt_data_q  <= rt_data_d;
         imm_q      <= imm_d;
         pc_plus4_q <= pc_plus4_d;
         rs_q       <= rs_d;
         rt_q       <= rt_d;
         rd_q       <= rd_d;
         funct_q    <= funct_d;
      end
   end

   assign ex_valid      = valid_q;
   assign ex_mem_write  = ctrl_q.mem_write;
   assign ex_reg_write  = ctrl_q.reg_write;
   assign ex_reg_dest   = ctrl_q.reg_dest;
   assign ex_mem_to_reg = ctrl_q.mem_to_reg;
   assign ex_alu_src    = ctrl_q.alu_src;
   assign ex_alu_op     = ctrl_q.alu_op;
   assign ex_branch     = ctrl_q.branch;
   assign ex_mem_read   = ctrl_q.mem_read;
   assign ex_rs_data    = rs_data_q;
   assign ex_rt_data    = rt_data_q;
   assign ex_imm        = imm_q;
   assign ex_pc_plus4   = pc_plus4_q;
   assign ex_rs         = rs_q;
   assign ex_rt         = rt_q;
   assign ex_rd         = rd_q;
   assign ex_funct      = funct_q;

`ifdef ID_EX_STATS_EN
   logic [31:0] stall_cnt_d, stall_cnt_q;
   logic [31:0] flush_cnt_d, flush_cnt_q;

   // Saturating event counters
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_out && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (flush && id_valid && (flush_cnt_q != 32'hFFFF_FFFF)) begin
         flush_cnt_d = flush_cnt_q + 32'd1;
      end
   end

   // Counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule
